// File: rtl/univ_shiftreg_p_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// shiftreg_pkg : operation modes and effective-count helper for univ_shiftreg_p
// Revision 1.0
// ----------------------------------------------------------------------------
package shiftreg_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'b000,
    SHR  = 3'b001,
    SHL  = 3'b010,
    LOAD = 3'b011,
    ROR  = 3'b100,
    ROL  = 3'b101,
    ASR  = 3'b110,
    CLR  = 3'b111
  } mode_t;

  // Only shift and rotate modes honour cnt; hold/load/clear are always single-step.
  function automatic logic uses_count(input mode_t mode);
    return (mode == SHR) || (mode == SHL) || (mode == ROR) ||
           (mode == ROL) || (mode == ASR);
  endfunction

  function automatic int unsigned eff_count(input int unsigned cnt,
                                            input int unsigned width);
    if (cnt == 0)     return 1;
    if (cnt > width)  return width;
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/univ_shift_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// univ_shift_step : combinational single-step next value of the shift register
// Revision 1.0
// ----------------------------------------------------------------------------
module univ_shift_step
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_t            mode,
  input  logic [WIDTH-1:0] cur,
  input  logic             din_r,
  input  logic             din_l,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    unique case (mode)
      HOLD: nxt = cur;
      SHR:  nxt = {din_r, cur[WIDTH-1:1]};
      SHL:  nxt = {cur[WIDTH-2:0], din_l};
      LOAD: nxt = val;
      ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
      ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      CLR:  nxt = '0;
      default: nxt = cur;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/univ_shiftreg_p.sv
`default_nettype none
// ----------------------------------------------------------------------------
// univ_shiftreg_p : WIDTH-bit universal shift register, one step per clock
// Revision 1.0
// ----------------------------------------------------------------------------
module univ_shiftreg_p
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       sel,
  input  logic [CNT_W-1:0] cnt,
  input  logic [WIDTH-1:0] val,
  input  logic             din_r,
  input  logic             din_l,
  output logic [WIDTH-1:0] dout,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             done_q, done_d;

  mode_t            sel_mode;
  mode_t            step_mode;
  logic [CNT_W-1:0] n_req;
  logic [WIDTH-1:0] step_nxt;
  logic             accept;

  assign sel_mode = mode_t'(sel);
  assign accept   = en && (state_q == S_IDLE);
  assign n_req    = uses_count(sel_mode)
                  ? CNT_W'(eff_count(32'(cnt), WIDTH))
                  : CNT_W'(1);
  assign step_mode = (state_q == S_RUN) ? mode_q : (accept ? sel_mode : HOLD);

  univ_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode  (step_mode),
    .cur   (dout_q),
    .din_r (din_r),
    .din_l (din_l),
    .val   (val),
    .nxt   (step_nxt)
  );

  // rem_q counts steps still to apply after the current edge's step.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          dout_d = step_nxt;
          if (n_req > CNT_W'(1)) begin
            state_d = S_RUN;
            mode_d  = sel_mode;
            rem_d   = n_req - CNT_W'(1);
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        dout_d = step_nxt;
        if (rem_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          mode_d  = HOLD;
          rem_d   = '0;
          done_d  = 1'b1;
        end else begin
          rem_d   = rem_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= HOLD;
      rem_q   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  assign dout   = dout_q;
  assign sout_r = dout_q[0];
  assign sout_l = dout_q[WIDTH-1];
  assign busy   = (state_q == S_RUN);
  assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_univ_shiftreg_p.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_univ_shiftreg_p : directed self-checking bench for univ_shiftreg_p (WIDTH=8)
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_univ_shiftreg_p;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] sel;
  logic [3:0] cnt;
  logic [7:0] val;
  logic       din_r;
  logic       din_l;
  logic [7:0] dout;
  logic       sout_r;
  logic       sout_l;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;
  int nbusy;

  univ_shiftreg_p #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sel    (sel),
    .cnt    (cnt),
    .val    (val),
    .din_r  (din_r),
    .din_l  (din_l),
    .dout   (dout),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input logic [2:0] s, input logic [3:0] c, input logic [7:0] v);
    en = 1'b1; sel = s; cnt = c; val = v;
    tick();
    en = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    en = 1'($urandom); sel = 3'($urandom); cnt = 4'($urandom);
    val = 8'($urandom); din_r = 1'($urandom); din_l = 1'($urandom);
    #2;
    chk("rst_dout", dout, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    tick();
    chk("rst_hold_dout", dout, 8'h00);
    en = 1'b0; sel = 3'b000; cnt = 4'd0; val = 8'h00; din_r = 1'b0; din_l = 1'b0;
    rst = 1'b1;
    tick();
    chk("idle1_dout", dout, 8'h00);
    chk("idle1_done", done, 1'b0);
    tick();
    chk("idle2_dout", dout, 8'h00);
    chk("idle2_done", done, 1'b0);

    // Load then shift right by 3 with din_r=1
    req(3'b011, 4'd0, 8'hC3);
    chk("ld_c3_dout", dout, 8'hC3);
    chk("ld_c3_done", done, 1'b1);
    chk("ld_c3_sout_r", sout_r, 1'b1);
    chk("ld_c3_sout_l", sout_l, 1'b1);
    tick();
    chk("ld_c3_done_off", done, 1'b0);
    din_r = 1'b1;
    req(3'b001, 4'd3, 8'h00);
    chk("shr1_dout", dout, 8'hE1);
    chk("shr1_busy", busy, 1'b1);
    chk("shr1_done", done, 1'b0);
    tick();
    chk("shr2_dout", dout, 8'hF0);
    chk("shr2_busy", busy, 1'b1);
    chk("shr2_sout_r", sout_r, 1'b0);
    tick();
    chk("shr3_dout", dout, 8'hF8);
    chk("shr3_busy", busy, 1'b0);
    chk("shr3_done", done, 1'b1);
    tick();
    chk("shr_done_off", done, 1'b0);
    din_r = 1'b0;

    // Rotate left by WIDTH returns the original value
    req(3'b011, 4'd0, 8'hA5);
    req(3'b101, 4'd8, 8'h00);
    chk("rol1_dout", dout, 8'h4B);
    count_busy(nbusy);
    chk("rol_busy_cycles", nbusy, 7);
    chk("rol_final", dout, 8'hA5);
    chk("rol_done", done, 1'b1);

    // Arithmetic shift right replicates the MSB
    req(3'b011, 4'd0, 8'h90);
    req(3'b110, 4'd2, 8'h00);
    chk("asr1_dout", dout, 8'hC8);
    chk("asr1_busy", busy, 1'b1);
    tick();
    chk("asr2_dout", dout, 8'hE4);
    chk("asr2_done", done, 1'b1);

    // Count clamps to WIDTH; cnt=0 means one step
    req(3'b011, 4'd0, 8'hFF);
    din_l = 1'b0;
    req(3'b010, 4'd12, 8'h00);
    count_busy(nbusy);
    chk("shl_clamp_busy_cycles", nbusy, 7);
    chk("shl_clamp_final", dout, 8'h00);
    chk("shl_clamp_done", done, 1'b1);
    req(3'b011, 4'd0, 8'h01);
    req(3'b010, 4'd0, 8'h00);
    chk("shl0_dout", dout, 8'h02);
    chk("shl0_busy", busy, 1'b0);
    chk("shl0_done", done, 1'b1);

    // Load request during a multi-step shift is ignored
    req(3'b011, 4'd0, 8'h80);
    din_r = 1'b0;
    req(3'b001, 4'd4, 8'h00);
    chk("busy_shr1_dout", dout, 8'h40);
    chk("busy_shr1_sout_l", sout_l, 1'b0);
    en = 1'b1; sel = 3'b011; cnt = 4'd0; val = 8'h55;
    tick();
    chk("busy_shr2_dout", dout, 8'h20);
    tick();
    chk("busy_shr3_dout", dout, 8'h10);
    tick();
    chk("busy_shr4_dout", dout, 8'h08);
    chk("busy_shr4_busy", busy, 1'b0);
    chk("busy_shr4_done", done, 1'b1);
    tick();
    en = 1'b0;
    chk("post_busy_load", dout, 8'h55);
    chk("post_busy_load_done", done, 1'b1);

    // Asynchronous reset in the middle of a rotate
    req(3'b011, 4'd0, 8'h81);
    req(3'b100, 4'd8, 8'h00);
    chk("ror1_dout", dout, 8'hC0);
    tick();
    chk("ror2_dout", dout, 8'h60);
    tick();
    chk("ror3_dout", dout, 8'h30);
    rst = 1'b0;
    #1;
    chk("midrst_dout", dout, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk("after_rst_done", done, 1'b0);
    chk("after_rst_dout", dout, 8'h00);
    tick();
    chk("after_rst_done2", done, 1'b0);
    chk("after_rst_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/univ_shiftreg_p.md
# univ_shiftreg_p

Parametrised universal shift register. It extends the 4-bit hold/shift-right/shift-left/load register to WIDTH bits and adds rotate, arithmetic shift, clear and multi-position shifts. A multi-position shift executes one position per clock, with a busy/done handshake. The block sits in the datapath as a general serialiser, deserialiser and bit-manipulation register.

## Interface

Parameters:
- WIDTH, default 8: register width in bits; must be at least 2.
- CNT_W, default $clog2(WIDTH)+1: width of the shift-count input.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-low.
- en  input  1  operation request.
- sel  input  3  operation select.
- cnt  input  CNT_W  number of positions for shift/rotate operations.
- val  input  WIDTH  parallel load value.
- din_r  input  1  serial input into the MSB on right shifts.
- din_l  input  1  serial input into the LSB on left shifts.
- dout  output  WIDTH  register contents.
- sout_r  output  1  equals dout[0], the next bit to leave on a right shift.
- sout_l  output  1  equals dout[WIDTH-1], the next bit to leave on a left shift.
- busy  output  1  a multi-step operation is in progress.
- done  output  1  one-cycle pulse marking completion of an accepted operation.

## Operation

- sel encoding (the 2-bit legacy codes are kept with sel[2]=0):
  - 000: hold.
  - 001: logical shift right; din_r enters the MSB.
  - 010: shift left; din_l enters the LSB.
  - 011: parallel load of val.
  - 100: rotate right.
  - 101: rotate left.
  - 110: arithmetic shift right; the MSB is replicated.
  - 111: clear to 0.
- Acceptance: a request is accepted on a rising edge where en=1 and busy=0. The first step is applied at that same edge.
- Shift and rotate codes (001, 010, 100, 101, 110) use the effective count N:
  - N = 1 when cnt=0.
  - N = WIDTH when cnt > WIDTH.
  - Otherwise N = cnt.
- Hold, load and clear always use N=1, regardless of cnt.
- Stepping when N > 1:
  - sel and the remaining count are latched at acceptance.
  - busy=1 for the following N-1 cycles.
  - One step is applied per edge using the latched mode.
- din_r and din_l are sampled live at every step edge; they are not latched.
- Requests while busy=1 are ignored: no queuing and no error flag. val is not used after acceptance.
- Rotate by N=WIDTH returns the original value.
- Reset (rst=0), at any time including mid-operation: dout=0, busy=0, done=0, and the latched mode and count are cleared. Outputs are valid immediately, without waiting for a clock edge.
- State machine:
  - IDLE -> IDLE on acceptance with N=1.
  - IDLE -> RUN on acceptance with N>1.
  - RUN -> IDLE on the edge applying the final step.

## Timing

- Single-step operation accepted at edge k: new dout visible after edge k; done=1 for the cycle between edges k and k+1.
- N-step operation accepted at edge k:
  - busy rises after edge k and falls after edge k+N-1.
  - Final dout is visible after edge k+N-1.
  - done=1 for exactly one cycle, between edges k+N-1 and k+N.
- Back-to-back: a new request can be accepted on the edge where busy=0 is sampled, i.e. edge k+N. That request may coincide with done=1 from the previous operation.
- sout_r and sout_l are combinational from the register, so they change with dout.

## Structure

- Package shiftreg_pkg holds:
  - the 3-bit mode enum (HOLD, SHR, SHL, LOAD, ROR, ROL, ASR, CLR);
  - a function computing the clamped effective count from cnt and WIDTH.
- Sub-module univ_shift_step: purely combinational one-step next-value logic. Inputs are mode, current value, din_r, din_l and val; output is the next value. The top level holds the register, the count down-counter, the IDLE/RUN FSM and done generation.

## Test plan

All scenarios use WIDTH=8.

1. Reset: hold rst=0 with random inputs -> dout=0x00, busy=0, done=0 immediately. Release reset and let 2 edges pass with en=0 -> dout stays 0x00 and done never pulses.
2. Load, then shift right: load 0xC3 -> dout=0xC3 and one done pulse. Then SHR with cnt=3, din_r=1 -> dout 0xE1, 0xF0, 0xF8 on successive edges; busy high for 2 cycles; done pulses once, after 0xF8.
3. Rotate and arithmetic shift:
   - Load 0xA5, then ROL with cnt=8 -> busy high for 7 cycles, final dout=0xA5.
   - Load 0x90, then ASR with cnt=2 -> 0xC8, then 0xE4.
4. Count clamping: load 0xFF, then SHL with cnt=12, din_l=0 -> clamped to 8 steps, final dout=0x00, busy high for 7 cycles. A further SHL with cnt=0 on 0x01 -> single step, dout=0x02, busy stays 0.
5. Request while busy: start SHR with cnt=4 on 0x80, din_r=0. Assert en with sel=011, val=0x55 while busy -> load ignored, final dout=0x08. A load issued on the first cycle with busy=0 is accepted.
6. Reset mid-operation: start ROR with cnt=8 on 0x81. Drop rst after 3 steps -> dout=0x00 and busy=0 asynchronously, and no done pulse follows.
